// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter: grant in IDLE, tx_start one cycle later, then
// track the frame via tx_ready. Optional watchdog (timeout_err) built with UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int NREQ           = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              tx_start,
    output logic [7:0]        tx_data_in,
    input  logic              tx_ready,
    output logic [2:0]        grant_id,
    output logic              busy
`ifdef UART_ARB_TIMEOUT_EN
    ,
    output logic              timeout_err
`endif
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] START     = 2'd1;
    localparam logic [1:0] WAIT_BUSY = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("uart_tx_arbiter: NREQ must be 2..8 and TIMEOUT_CYCLES at least 2");
    end

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [2:0] last_grant;
    logic [2:0] winner;
    logic       found;
    logic [7:0] win_data;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wd_cnt;
    logic          wd_expire;
`endif

    // Search starts one past the previous winner so every requester is reached within NREQ grants.
    always_comb begin : rr_pick
        int idx;
        idx    = 0;
        winner = '0;
        found  = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_grant) + k) % NREQ;
            if (!found && req_valid[IW'(idx)]) begin
                found  = 1'b1;
                winner = 3'(idx);
            end
        end
    end

    always_comb begin
        win_data = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == 3'(i)) win_data = req_data[8*i +: 8];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (tx_ready && found) state_nxt = START;
            START:     state_nxt = WAIT_BUSY;
            WAIT_BUSY: if (!tx_ready) state_nxt = WAIT_DONE;
            WAIT_DONE: if (tx_ready) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
`ifdef UART_ARB_TIMEOUT_EN
        if (wd_expire) state_nxt = IDLE;
`endif
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tx_data_in <= 8'h00;
            grant_id   <= 3'd0;
            last_grant <= 3'(NREQ - 1);
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == START) begin
                tx_data_in <= win_data;
                grant_id   <= winner;
                last_grant <= winner;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = (state == START) && (grant_id == 3'(i));
        end
    end

    assign tx_start = (state == START);
    assign busy     = (state != IDLE);

`ifdef UART_ARB_TIMEOUT_EN
    // Counter restarts on every state change, so each wait state gets its own full budget.
    assign wd_expire = ((state == WAIT_BUSY) || (state == WAIT_DONE)) &&
                       (wd_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= wd_expire;
            if (state_nxt != state) wd_cnt <= '0;
            else if (state == WAIT_BUSY || state == WAIT_DONE) wd_cnt <= wd_cnt + CW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-based requesters, a UART model with programmable frame length,
// and a round-robin reference model computed over copies of the pending byte queues.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;

    logic              clk_sys = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   req_ready;
    logic              tx_start;
    logic [7:0]        tx_data_in;
    logic              tx_ready = 1'b1;
    logic [2:0]        grant_id;
    logic              busy;
`ifdef UART_ARB_TIMEOUT_EN
    logic              timeout_err;
`endif

    uart_tx_arbiter #(.NREQ(NREQ)) dut (
        .clk_sys    (clk_sys),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .tx_start   (tx_start),
        .tx_data_in (tx_data_in),
        .tx_ready   (tx_ready),
        .grant_id   (grant_id),
        .busy       (busy)
`ifdef UART_ARB_TIMEOUT_EN
        ,
        .timeout_err(timeout_err)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    int n_cmp = 0;
    int n_bad = 0;
    bit uart_auto = 1'b0;
    int uart_lat = 10;
    int cyc = 0;
    int last_start = -100;
    int rr_bad = 0;
    int gap_bad = 0;
    int model_last = NREQ - 1;

    logic [7:0] q [NREQ][$];
    logic [2:0] log_id[$];
    logic [7:0] log_dat[$];
    logic [2:0] exp_id[$];
    logic [7:0] exp_dat[$];

    task automatic drive_reqs();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]       = (q[i].size() > 0);
            req_data[8*i +: 8] = (q[i].size() > 0) ? q[i][0] : 8'h00;
        end
    endtask

    task automatic load(input int r, input logic [7:0] d);
        q[r].push_back(d);
    endtask

    // Expected transmit order: repeatedly pick the first non-empty queue after the last winner.
    task automatic build_expected();
        logic [7:0] cp [NREQ][$];
        int total;
        int w;
        total = 0;
        exp_id.delete(); exp_dat.delete(); log_id.delete(); log_dat.delete();
        for (int i = 0; i < NREQ; i++) begin
            cp[i] = q[i];
            total += q[i].size();
        end
        repeat (total) begin
            w = -1;
            for (int k = 1; k <= NREQ; k++) begin
                if (w < 0 && cp[(model_last + k) % NREQ].size() > 0) w = (model_last + k) % NREQ;
            end
            exp_id.push_back(3'(w));
            exp_dat.push_back(cp[w].pop_front());
            model_last = w;
        end
    endtask

    task automatic wait_frames(input int n, output bit ok);
        int t;
        t = 0;
        while ((log_id.size() < n || busy !== 1'b0) && t < 1000) begin
            @(negedge clk_sys);
            t++;
        end
        ok = (t < 1000);
    endtask

    task automatic do_reset();
        @(negedge clk_sys);
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) q[i].delete();
        drive_reqs();
        @(negedge clk_sys);
        rst = 1'b0;
        model_last = NREQ - 1;
    endtask

    // Requester side and transfer monitor, all sampled on the falling edge.
    initial forever begin
        @(negedge clk_sys);
        cyc++;
        if (rst) last_start = -100;
        if (tx_start === 1'b1) begin
            log_id.push_back(grant_id);
            log_dat.push_back(tx_data_in);
            if (req_ready !== (NREQ'(1) << grant_id)) rr_bad++;
            if (cyc - last_start < 4) gap_bad++;
            last_start = cyc;
        end else if (req_ready !== '0) begin
            rr_bad++;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i] === 1'b1 && q[i].size() > 0) void'(q[i].pop_front());
        end
        drive_reqs();
    end

    initial forever begin
        @(negedge clk_sys);
        if (uart_auto && tx_start === 1'b1) begin
            tx_ready = 1'b0;
            repeat (uart_lat) @(negedge clk_sys);
            tx_ready = 1'b1;
        end
    end

    task automatic test_reset();
        @(negedge clk_sys);
        n_cmp += 5;
        if (req_ready !== '0)     begin n_bad++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
        if (tx_start !== 1'b0)    begin n_bad++; $display("FAIL reset_tx_start got %b want 0", tx_start); end
        if (tx_data_in !== 8'h00) begin n_bad++; $display("FAIL reset_tx_data got %h want 00", tx_data_in); end
        if (grant_id !== 3'd0)    begin n_bad++; $display("FAIL reset_grant_id got %0d want 0", grant_id); end
        if (busy !== 1'b0)        begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        rst = 1'b0;
        model_last = NREQ - 1;
    endtask

    task automatic test_single_request();
        uart_auto = 1'b0;
        tx_ready = 1'b1;
        load(0, 8'hA5);
        drive_reqs();
        @(negedge clk_sys);
        n_cmp += 5;
        if (tx_start !== 1'b1)      begin n_bad++; $display("FAIL single_tx_start got %b want 1", tx_start); end
        if (req_ready !== 4'b0001)  begin n_bad++; $display("FAIL single_req_ready got %b want 0001", req_ready); end
        if (tx_data_in !== 8'hA5)   begin n_bad++; $display("FAIL single_data got %h want a5", tx_data_in); end
        if (grant_id !== 3'd0)      begin n_bad++; $display("FAIL single_grant got %0d want 0", grant_id); end
        if (busy !== 1'b1)          begin n_bad++; $display("FAIL single_busy got %b want 1", busy); end
        @(negedge clk_sys);
        n_cmp += 2;
        if (tx_start !== 1'b0 || req_ready !== '0)
            begin n_bad++; $display("FAIL single_pulse_width got start=%b ready=%b want 0/0", tx_start, req_ready); end
        if (busy !== 1'b1) begin n_bad++; $display("FAIL single_wait_busy got %b want 1", busy); end
        @(negedge clk_sys);
        tx_ready = 1'b0;
        repeat (3) @(negedge clk_sys);
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL single_wait_done got %b want 1", busy); end
        tx_ready = 1'b1;
        @(negedge clk_sys);
        n_cmp += 2;
        if (busy !== 1'b0)        begin n_bad++; $display("FAIL single_idle got %b want 0", busy); end
        if (tx_data_in !== 8'hA5) begin n_bad++; $display("FAIL single_hold got %h want a5", tx_data_in); end
        model_last = 0;
    endtask

    task automatic test_backpressure();
        tx_ready = 1'b0;
        load(2, 8'h5C);
        drive_reqs();
        repeat (3) @(negedge clk_sys);
        n_cmp += 2;
        if (busy !== 1'b0)     begin n_bad++; $display("FAIL bp_busy got %b want 0", busy); end
        if (req_ready !== '0)  begin n_bad++; $display("FAIL bp_ready got %b want 0", req_ready); end
        tx_ready = 1'b1;
        @(negedge clk_sys);
        n_cmp += 2;
        if (grant_id !== 3'd2)                         begin n_bad++; $display("FAIL bp_grant got %0d want 2", grant_id); end
        if (tx_start !== 1'b1 || tx_data_in !== 8'h5C) begin n_bad++; $display("FAIL bp_start got %b/%h want 1/5c", tx_start, tx_data_in); end
        tx_ready = 1'b0;
        repeat (3) @(negedge clk_sys);
        tx_ready = 1'b1;
        repeat (2) @(negedge clk_sys);
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL bp_done got %b want 0", busy); end
        model_last = 2;
    endtask

    task automatic test_contention();
        bit ok;
        do_reset();
        uart_auto = 1'b1;
        uart_lat = 10;
        load(0, 8'h10); load(1, 8'h21); load(2, 8'h32); load(3, 8'h43);
        drive_reqs();
        build_expected();
        wait_frames(4, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL contention_frames got %0d want 4", log_id.size()); end
        for (int i = 0; i < exp_id.size() && i < log_id.size(); i++) begin
            n_cmp++;
            if (log_id[i] !== 3'(i) || log_dat[i] !== exp_dat[i]) begin
                n_bad++;
                $display("FAIL contention[%0d] got id=%0d dat=%h want id=%0d dat=%h", i, log_id[i], log_dat[i], i, exp_dat[i]);
            end
        end
    endtask

    task automatic test_fairness();
        bit ok;
        do_reset();
        for (int j = 0; j < 4; j++) begin
            load(1, 8'($urandom));
            load(3, 8'($urandom));
        end
        drive_reqs();
        build_expected();
        wait_frames(8, ok);
        n_cmp++;
        if (!ok || log_id.size() != 8) begin n_bad++; $display("FAIL fairness_frames got %0d want 8", log_id.size()); end
        for (int i = 0; i < exp_id.size() && i < log_id.size(); i++) begin
            n_cmp++;
            if (log_id[i] !== ((i % 2 == 0) ? 3'd1 : 3'd3) || log_dat[i] !== exp_dat[i]) begin
                n_bad++;
                $display("FAIL fairness[%0d] got id=%0d dat=%h want id=%0d dat=%h", i, log_id[i], log_dat[i], exp_id[i], exp_dat[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        uart_lat = 2;
        gap_bad = 0;
        load(2, 8'h01); load(2, 8'h02); load(2, 8'h03);
        drive_reqs();
        build_expected();
        wait_frames(3, ok);
        n_cmp += 2;
        if (!ok) begin n_bad++; $display("FAIL b2b_frames got %0d want 3", log_id.size()); end
        if (gap_bad !== 0) begin n_bad++; $display("FAIL b2b_gap got %0d short gaps want 0", gap_bad); end
        for (int i = 0; i < exp_id.size() && i < log_id.size(); i++) begin
            n_cmp++;
            if (log_id[i] !== 3'd2 || log_dat[i] !== exp_dat[i]) begin
                n_bad++;
                $display("FAIL b2b[%0d] got id=%0d dat=%h want id=2 dat=%h", i, log_id[i], log_dat[i], exp_dat[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        uart_auto = 1'b0;
        do_reset();
        tx_ready = 1'b1;
        load(1, 8'h77);
        drive_reqs();
        @(negedge clk_sys);
        n_cmp++;
        if (grant_id !== 3'd1) begin n_bad++; $display("FAIL mid_grant got %0d want 1", grant_id); end
        tx_ready = 1'b0;
        repeat (2) @(negedge clk_sys);
        #2 rst = 1'b1;
        #1;
        n_cmp += 3;
        if (busy !== 1'b0 || tx_start !== 1'b0 || req_ready !== '0)
            begin n_bad++; $display("FAIL mid_ctrl got busy=%b start=%b ready=%b want 0", busy, tx_start, req_ready); end
        if (tx_data_in !== 8'h00) begin n_bad++; $display("FAIL mid_data got %h want 00", tx_data_in); end
        if (grant_id !== 3'd0)    begin n_bad++; $display("FAIL mid_gid got %0d want 0", grant_id); end
        @(negedge clk_sys);
        rst = 1'b0;
        model_last = NREQ - 1;
        tx_ready = 1'b1;
        uart_auto = 1'b1;
        uart_lat = 5;
        load(0, 8'h5A); load(3, 8'h3C);
        drive_reqs();
        build_expected();
        wait_frames(2, ok);
        n_cmp++;
        if (!ok || log_id.size() != 2) begin n_bad++; $display("FAIL mid_frames got %0d want 2", log_id.size()); end
        for (int i = 0; i < exp_id.size() && i < log_id.size(); i++) begin
            n_cmp++;
            if (log_id[i] !== exp_id[i] || log_dat[i] !== exp_dat[i]) begin
                n_bad++;
                $display("FAIL mid[%0d] got id=%0d dat=%h want id=%0d dat=%h", i, log_id[i], log_dat[i], exp_id[i], exp_dat[i]);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        int total;
        for (int it = 0; it < 8; it++) begin
            total = 0;
            uart_lat = int'($urandom_range(2, 12));
            for (int r = 0; r < NREQ; r++) begin
                int n;
                n = int'($urandom_range(0, 3));
                for (int j = 0; j < n; j++) load(r, 8'($urandom));
                total += n;
            end
            if (total == 0) load(int'($urandom_range(0, NREQ - 1)), 8'($urandom));
            drive_reqs();
            build_expected();
            wait_frames(exp_id.size(), ok);
            n_cmp++;
            if (!ok || log_id.size() != exp_id.size())
                begin n_bad++; $display("FAIL random%0d_frames got %0d want %0d", it, log_id.size(), exp_id.size()); end
            for (int i = 0; i < exp_id.size() && i < log_id.size(); i++) begin
                n_cmp++;
                if (log_id[i] !== exp_id[i] || log_dat[i] !== exp_dat[i]) begin
                    n_bad++;
                    $display("FAIL random%0d[%0d] got id=%0d dat=%h want id=%0d dat=%h", it, i, log_id[i], log_dat[i], exp_id[i], exp_dat[i]);
                end
            end
        end
    endtask

    task automatic test_protocol();
        n_cmp += 2;
        if (rr_bad !== 0)  begin n_bad++; $display("FAIL req_ready_onehot got %0d bad cycles want 0", rr_bad); end
        if (gap_bad !== 0) begin n_bad++; $display("FAIL start_interval got %0d short gaps want 0", gap_bad); end
    endtask

    initial begin
        test_reset();
        test_single_request();
        test_backpressure();
        test_contention();
        test_fairness();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        test_protocol();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout got no finish want finish before %0d cycles", 90000);
        $fatal(1, "bench timeout");
    end

endmodule
